// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ibex writeback stage.
package ibex_pkg;

  parameter int unsigned RegFileAddrW = 5;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_stage.sv
// Single-entry writeback stage: holds one retiring instruction and drives the RF write port.
// Optional ID forwarding ports are enabled by defining IBEX_WB_FWD_EN.
module ibex_wb_stage
  import ibex_pkg::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_wb_i,
  input  logic [1:0]              instr_type_wb_i,
  input  logic [RegFileAddrW-1:0] rf_waddr_id_i,
  input  logic [31:0]             rf_wdata_id_i,
  input  logic                    rf_we_id_i,
  input  logic [31:0]             pc_id_i,
  input  logic                    lsu_resp_valid_i,
  input  logic                    lsu_resp_err_i,
  input  logic [31:0]             lsu_rdata_i,
  output logic                    ready_wb_o,
  output logic [RegFileAddrW-1:0] rf_waddr_wb_o,
  output logic [31:0]             rf_wdata_wb_o,
  output logic                    rf_we_wb_o,
  output logic [31:0]             pc_wb_o,
  output logic                    instr_done_wb_o,
  output logic                    perf_instr_ret_wb_o,
  output logic                    outstanding_load_wb_o,
`ifdef IBEX_WB_FWD_EN
  output logic                    outstanding_store_wb_o,
  output logic [31:0]             rf_wdata_fwd_wb_o,
  output logic                    rf_we_fwd_wb_o
`else
  output logic                    outstanding_store_wb_o
`endif
);

  logic                    wb_valid_q;
  wb_instr_type_e          type_q;
  logic                    we_q;
  logic [RegFileAddrW-1:0] waddr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             pc_q;

  logic wb_done;
  logic capture;
  logic is_load;
  logic is_store;

  assign is_load  = (type_q == WB_INSTR_LOAD);
  assign is_store = (type_q == WB_INSTR_STORE);
  assign wb_done  = (type_q == WB_INSTR_OTHER) | lsu_resp_valid_i;

  assign instr_done_wb_o = wb_valid_q & wb_done;
  assign ready_wb_o      = ~wb_valid_q | wb_done;
  assign capture         = en_wb_i & ready_wb_o;

  // Control flops always reset so the entry is empty out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      type_q     <= WB_INSTR_OTHER;
      we_q       <= 1'b0;
    end else if (capture) begin
      wb_valid_q <= 1'b1;
      type_q     <= wb_instr_type_e'(instr_type_wb_i);
      we_q       <= rf_we_id_i;
    end else if (instr_done_wb_o) begin
      wb_valid_q <= 1'b0;
    end
  end

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q <= '0;
        wdata_q <= '0;
        pc_q    <= '0;
      end else if (capture) begin
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
        pc_q    <= pc_id_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (capture) begin
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
        pc_q    <= pc_id_i;
      end
    end
  end

  // Data outputs are masked by valid so unreset data flops never leak out.
  assign rf_waddr_wb_o = wb_valid_q ? waddr_q : '0;
  assign pc_wb_o       = wb_valid_q ? pc_q : '0;
  assign rf_wdata_wb_o = wb_valid_q ? (is_load ? lsu_rdata_i : wdata_q) : '0;

  assign rf_we_wb_o = instr_done_wb_o & we_q & ~is_store &
                      ~(is_load & lsu_resp_err_i) & (waddr_q != '0);

  assign perf_instr_ret_wb_o    = instr_done_wb_o & ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign outstanding_load_wb_o  = wb_valid_q & is_load;
  assign outstanding_store_wb_o = wb_valid_q & is_store;

`ifdef IBEX_WB_FWD_EN
  assign rf_wdata_fwd_wb_o = wb_valid_q ? wdata_q : '0;
  assign rf_we_fwd_wb_o    = wb_valid_q & we_q & (type_q == WB_INSTR_OTHER);
`endif

  a_no_en_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni) en_wb_i |-> ready_wb_o);

  a_no_stray_lsu_resp : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (outstanding_load_wb_o | outstanding_store_wb_o));

endmodule

// File: tb/tb_ibex_wb_stage.sv
// Directed self-checking bench for ibex_wb_stage.
module tb_ibex_wb_stage;
  import ibex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_wb_i;
  logic [1:0]  instr_type_wb_i;
  logic [4:0]  rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic        rf_we_id_i;
  logic [31:0] pc_id_i;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic [31:0] lsu_rdata_i;
  logic        ready_wb_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic        rf_we_wb_o;
  logic [31:0] pc_wb_o;
  logic        instr_done_wb_o;
  logic        perf_instr_ret_wb_o;
  logic        outstanding_load_wb_o;
  logic        outstanding_store_wb_o;

  int unsigned passed = 0;
  int unsigned total  = 0;

  ibex_wb_stage #(.ResetAll(1'b0)) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .en_wb_i                (en_wb_i),
    .instr_type_wb_i        (instr_type_wb_i),
    .rf_waddr_id_i          (rf_waddr_id_i),
    .rf_wdata_id_i          (rf_wdata_id_i),
    .rf_we_id_i             (rf_we_id_i),
    .pc_id_i                (pc_id_i),
    .lsu_resp_valid_i       (lsu_resp_valid_i),
    .lsu_resp_err_i         (lsu_resp_err_i),
    .lsu_rdata_i            (lsu_rdata_i),
    .ready_wb_o             (ready_wb_o),
    .rf_waddr_wb_o          (rf_waddr_wb_o),
    .rf_wdata_wb_o          (rf_wdata_wb_o),
    .rf_we_wb_o             (rf_we_wb_o),
    .pc_wb_o                (pc_wb_o),
    .instr_done_wb_o        (instr_done_wb_o),
    .perf_instr_ret_wb_o    (perf_instr_ret_wb_o),
    .outstanding_load_wb_o  (outstanding_load_wb_o),
    .outstanding_store_wb_o (outstanding_store_wb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to the next cycle's drive point; inputs default to idle.
  task automatic next_cycle();
    @(negedge clk_i);
    en_wb_i          = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    lsu_rdata_i      = '0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d,
                       input logic we, input logic [31:0] pc);
    en_wb_i         = 1'b1;
    instr_type_wb_i = t;
    rf_waddr_id_i   = a;
    rf_wdata_id_i   = d;
    rf_we_id_i      = we;
    pc_id_i         = pc;
  endtask

  initial begin
    rst_ni           = 1'b0;
    en_wb_i          = 1'b0;
    instr_type_wb_i  = WB_INSTR_OTHER;
    rf_waddr_id_i    = '0;
    rf_wdata_id_i    = '0;
    rf_we_id_i       = 1'b0;
    pc_id_i          = '0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    lsu_rdata_i      = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_we",    {31'd0, rf_we_wb_o}, 32'd0);
    chk("rst_done",  {31'd0, instr_done_wb_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_wb_o}, 32'd1);
    chk("rst_pc",    pc_wb_o, 32'd0);
    chk("rst_wdata", rf_wdata_wb_o, 32'd0);
    rst_ni = 1'b1;

    // OTHER to x5
    next_cycle();
    issue(WB_INSTR_OTHER, 5'd5, 32'hDEADBEEF, 1'b1, 32'h100);
    #1;
    chk("oth_ready_in", {31'd0, ready_wb_o}, 32'd1);
    chk("oth_we_empty", {31'd0, rf_we_wb_o}, 32'd0);
    next_cycle();
    #1;
    chk("oth_we",    {31'd0, rf_we_wb_o}, 32'd1);
    chk("oth_waddr", {27'd0, rf_waddr_wb_o}, 32'd5);
    chk("oth_wdata", rf_wdata_wb_o, 32'hDEADBEEF);
    chk("oth_pc",    pc_wb_o, 32'h100);
    chk("oth_ret",   {31'd0, perf_instr_ret_wb_o}, 32'd1);
    next_cycle();
    #1;
    chk("oth_ret_end", {31'd0, perf_instr_ret_wb_o}, 32'd0);
    chk("oth_we_end",  {31'd0, rf_we_wb_o}, 32'd0);

    // LOAD to x3 with 3 wait cycles
    issue(WB_INSTR_LOAD, 5'd3, 32'h0000AAAA, 1'b1, 32'h104);
    for (int unsigned i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      chk("ld_wait_ready", {31'd0, ready_wb_o}, 32'd0);
      chk("ld_wait_outst", {31'd0, outstanding_load_wb_o}, 32'd1);
      chk("ld_wait_we",    {31'd0, rf_we_wb_o}, 32'd0);
    end
    next_cycle();
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'h12345678;
    #1;
    chk("ld_we",    {31'd0, rf_we_wb_o}, 32'd1);
    chk("ld_waddr", {27'd0, rf_waddr_wb_o}, 32'd3);
    chk("ld_wdata", rf_wdata_wb_o, 32'h12345678);
    chk("ld_ready", {31'd0, ready_wb_o}, 32'd1);
    chk("ld_outst", {31'd0, outstanding_load_wb_o}, 32'd1);
    chk("ld_ret",   {31'd0, perf_instr_ret_wb_o}, 32'd1);
    next_cycle();
    #1;
    chk("ld_drained", {31'd0, outstanding_load_wb_o}, 32'd0);

    // LOAD with bus error
    issue(WB_INSTR_LOAD, 5'd7, 32'h0, 1'b1, 32'h108);
    next_cycle();
    lsu_resp_valid_i = 1'b1;
    lsu_resp_err_i   = 1'b1;
    #1;
    chk("err_we",   {31'd0, rf_we_wb_o}, 32'd0);
    chk("err_ret",  {31'd0, perf_instr_ret_wb_o}, 32'd0);
    chk("err_done", {31'd0, instr_done_wb_o}, 32'd1);
    next_cycle();
    #1;
    chk("err_drain_outst", {31'd0, outstanding_load_wb_o}, 32'd0);
    chk("err_drain_done",  {31'd0, instr_done_wb_o}, 32'd0);
    chk("err_drain_ready", {31'd0, ready_wb_o}, 32'd1);

    // Back-to-back OTHER, x1..x8
    for (int unsigned i = 1; i <= 8; i++) begin
      issue(WB_INSTR_OTHER, 5'(i), 32'h11 * i, 1'b1, 32'h200 + 4 * i);
      #1;
      chk("b2b_ready", {31'd0, ready_wb_o}, 32'd1);
      if (i > 1) begin
        chk("b2b_we",    {31'd0, rf_we_wb_o}, 32'd1);
        chk("b2b_waddr", {27'd0, rf_waddr_wb_o}, i - 1);
        chk("b2b_wdata", rf_wdata_wb_o, 32'h11 * (i - 1));
      end
      next_cycle();
    end
    #1;
    chk("b2b_last_we",    {31'd0, rf_we_wb_o}, 32'd1);
    chk("b2b_last_waddr", {27'd0, rf_waddr_wb_o}, 32'd8);
    chk("b2b_last_wdata", rf_wdata_wb_o, 32'h88);
    next_cycle();

    // OTHER to x0: retires but never writes
    issue(WB_INSTR_OTHER, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h300);
    next_cycle();
    #1;
    chk("x0_we",   {31'd0, rf_we_wb_o}, 32'd0);
    chk("x0_ret",  {31'd0, perf_instr_ret_wb_o}, 32'd1);
    chk("x0_done", {31'd0, instr_done_wb_o}, 32'd1);

    // STORE with we=1 never writes the RF
    issue(WB_INSTR_STORE, 5'd9, 32'hCAFEF00D, 1'b1, 32'h304);
    next_cycle();
    #1;
    chk("st_wait_outst", {31'd0, outstanding_store_wb_o}, 32'd1);
    chk("st_wait_ready", {31'd0, ready_wb_o}, 32'd0);
    next_cycle();
    lsu_resp_valid_i = 1'b1;
    #1;
    chk("st_we",    {31'd0, rf_we_wb_o}, 32'd0);
    chk("st_ret",   {31'd0, perf_instr_ret_wb_o}, 32'd1);
    chk("st_done",  {31'd0, instr_done_wb_o}, 32'd1);
    chk("st_outst", {31'd0, outstanding_store_wb_o}, 32'd1);
    next_cycle();

    // Reset while a LOAD is pending
    issue(WB_INSTR_LOAD, 5'd4, 32'h0, 1'b1, 32'h400);
    next_cycle();
    #1;
    chk("rl_outst_pre", {31'd0, outstanding_load_wb_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rl_outst", {31'd0, outstanding_load_wb_o}, 32'd0);
    chk("rl_waddr", {27'd0, rf_waddr_wb_o}, 32'd0);
    chk("rl_pc",    pc_wb_o, 32'd0);
    chk("rl_done",  {31'd0, instr_done_wb_o}, 32'd0);
    chk("rl_ready", {31'd0, ready_wb_o}, 32'd1);
    next_cycle();
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'h55AA55AA;
    #1;
    chk("rl_stray_we",    {31'd0, rf_we_wb_o}, 32'd0);
    chk("rl_stray_ret",   {31'd0, perf_instr_ret_wb_o}, 32'd0);
    chk("rl_stray_wdata", rf_wdata_wb_o, 32'd0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    #1;
    chk("rl_post_we",    {31'd0, rf_we_wb_o}, 32'd0);
    chk("rl_post_outst", {31'd0, outstanding_load_wb_o}, 32'd0);
    chk("rl_post_ready", {31'd0, ready_wb_o}, 32'd1);

    next_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
